// File: rtl/onchip_mem_stream_loader_if.sv
// Stream-side byte handshake and memory-side single-port write bus for the loader.
// The loader takes the master modport; the byte source and memory take the slave modport.
interface onchip_mem_stream_loader_if #(
    parameter int ADDR_W = 14
) ();
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    modport master (
        input  s_data, s_valid, s_last,
        output s_ready,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output s_data, s_valid, s_last,
        input  s_ready,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/onchip_mem_stream_loader.sv
// Packs an 8-bit valid/ready byte stream little-endian into 32-bit words and writes
// them to consecutive on-chip memory word addresses, wrapping at DEPTH-1.
module onchip_mem_stream_loader #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10240
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          start_addr,
    onchip_mem_stream_loader_if.master bus,
    output logic                       busy,
    output logic                       done,
    output logic                       wrapped,
    output logic [ADDR_W:0]            word_count
);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic              s_ready_q, busy_q, done_q, cs_q;
    logic              hs;

    assign hs = bus.s_valid & s_ready_q;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        last_d    = last_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = start_addr;
                    lane_d    = '0;
                    last_d    = 1'b0;
                    data_d    = '0;
                    be_d      = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (hs) begin
                    data_d[{lane_q, 3'b000} +: 8] = bus.s_data;
                    be_d[lane_q] = 1'b1;
                    if (lane_q == 2'd3 || bus.s_last) begin
                        last_d  = bus.s_last;
                        state_d = WRITE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
                if (addr_q == ADDR_W'(DEPTH - 1)) begin
                    addr_d    = '0;
                    wrapped_d = 1'b1;
                end else begin
                    addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                lane_d  = '0;
                data_d  = '0;
                be_d    = '0;
                state_d = last_q ? DONE : FILL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status strobes are decoded from the next state so every output stays a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            last_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            s_ready_q <= (state_d == FILL);
            busy_q    <= (state_d == FILL) || (state_d == WRITE);
            done_q    <= (state_d == DONE);
            cs_q      <= (state_d == WRITE);
        end
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = cs_q;
    assign bus.mem_writedata  = data_q;
    assign bus.mem_clken      = 1'b1;
    assign busy               = busy_q;
    assign done               = done_q;
    assign wrapped            = wrapped_q;
    assign word_count         = count_q;
endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Scoreboard bench for onchip_mem_stream_loader: expected memory writes are queued
// when a load is driven and checked by a monitor as the write cycles appear.
module tb_onchip_mem_stream_loader;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 10240;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              busy, done, wrapped;
    logic [ADDR_W:0]   word_count;

    onchip_mem_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

    onchip_mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .bus(bus), .busy(busy), .done(done), .wrapped(wrapped), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    time last_wr_t = 0;
    time prev_wr_t = 0;

    // Write monitor: every write cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_write === 1'b1) begin
            prev_wr_t = last_wr_t;
            last_wr_t = $time;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h be=%b, required no write",
                         bus.mem_address, bus.mem_writedata, bus.mem_byteenable);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_address !== e.addr || bus.mem_writedata !== e.data ||
                    bus.mem_byteenable !== e.be) begin
                    n_err++;
                    $display("FAIL write_contents: got addr=%0h data=%08h be=%b, required addr=%0h data=%08h be=%b",
                             bus.mem_address, bus.mem_writedata, bus.mem_byteenable, e.addr, e.data, e.be);
                end
            end
            n_cmp++;
            if (bus.s_ready !== 1'b0 || bus.mem_chipselect !== 1'b1) begin
                n_err++;
                $display("FAIL write_cycle_ctrl: got s_ready=%b cs=%b, required s_ready=0 cs=1",
                         bus.s_ready, bus.mem_chipselect);
            end
        end
    end

    task automatic push_expected(input logic [ADDR_W-1:0] a0, input logic [127:0] v, input int n,
                                 output logic exp_wrap, output int exp_words);
        logic [ADDR_W-1:0] a;
        int lane;
        wr_t w;
        a = a0; lane = 0; exp_wrap = 1'b0; exp_words = 0;
        w.addr = a; w.data = '0; w.be = '0;
        for (int i = 0; i < n; i++) begin
            w.data[8*lane +: 8] = v[8*i +: 8];
            w.be[lane] = 1'b1;
            lane++;
            if (lane == 4 || i == n - 1) begin
                w.addr = a;
                exp_q.push_back(w);
                exp_words++;
                if (int'(a) == DEPTH - 1) begin
                    a = '0;
                    exp_wrap = 1'b1;
                end else begin
                    a = a + 1'b1;
                end
                lane = 0; w.data = '0; w.be = '0;
            end
        end
    endtask

    // Drives one complete load and checks start response, completion and final status.
    task automatic run_load(input string name, input logic [ADDR_W-1:0] a, input logic [127:0] v,
                            input int n, input bit gaps, input int mid_start_idx);
        logic exp_wrap;
        int   exp_words;
        bit   ok;
        push_expected(a, v, n, exp_wrap, exp_words);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start_ack: got busy=%b s_ready=%b, required 1 1", name, busy, bus.s_ready);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    bus.s_valid = 1'b0;
                    bus.s_data  = 8'($urandom);
                    bus.s_last  = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = v[8*i +: 8];
            bus.s_last  = (i == n - 1);
            if (i == mid_start_idx) begin
                start = 1'b1; start_addr = 14'h0100;
            end
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (bus.s_ready === 1'b1) ok = 1'b1;
                @(posedge clk); #1;
            end
            start = 1'b0;
            if (!ok) begin
                n_cmp++; n_err++;
                $display("FAIL %s_handshake_timeout: got s_ready=0 for 50 cycles at byte %0d, required 1", name, i);
                bus.s_valid = 1'b0;
                return;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_done_timeout: got no done in 20 cycles, required done pulse", name);
            return;
        end
        n_cmp++;
        if (word_count !== (ADDR_W+1)'(exp_words) || wrapped !== exp_wrap || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_status: got word_count=%0d wrapped=%b busy=%b, required %0d %b 0",
                     name, word_count, wrapped, busy, exp_words, exp_wrap);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_writes: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || word_count !== (ADDR_W+1)'(exp_words) || wrapped !== exp_wrap) begin
            n_err++;
            $display("FAIL %s_after_done: got done=%b word_count=%0d wrapped=%b, required 0 %0d %b",
                     name, done, word_count, wrapped, exp_words, exp_wrap);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (bus.s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrapped !== 1'b0 ||
            bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_byteenable !== 4'h0 ||
            bus.mem_address !== '0 || bus.mem_writedata !== 32'h0 || word_count !== '0 ||
            bus.mem_clken !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b wrap=%b cs=%b wr=%b be=%b addr=%0h data=%08h cnt=%0d clken=%b, required all 0 and clken=1",
                     name, bus.s_ready, busy, done, wrapped, bus.mem_chipselect, bus.mem_write,
                     bus.mem_byteenable, bus.mem_address, bus.mem_writedata, word_count, bus.mem_clken);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; start_addr = '0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
        #3;
        check_reset_outputs("reset_state");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_clken !== 1'b1 || bus.s_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got clken=%b s_ready=%b busy=%b, required 1 0 0",
                     bus.mem_clken, bus.s_ready, busy);
        end
    endtask

    task automatic test_full_word();
        run_load("full_word", 14'h0010, 128'h8877665544332211, 8, 1'b0, -1);
        n_cmp++;
        if (last_wr_t - prev_wr_t !== 50) begin
            n_err++;
            $display("FAIL full_word_spacing: got %0t between writes, required 50", last_wr_t - prev_wr_t);
        end
    endtask

    task automatic test_partial_tail();
        run_load("partial_tail", 14'h0000, 128'hEEDDCCBBAA, 5, 1'b0, -1);
    endtask

    task automatic test_wrap();
        run_load("wrap", 14'(DEPTH - 1), 128'h0807060504030201, 8, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 11; i++) v[8*i +: 8] = 8'($urandom);
        run_load("backpressure_a", 14'h0300, v, 11, 1'b1, -1);
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'($urandom);
        run_load("backpressure_b", 14'h1234, v, 16, 1'b1, -1);
    endtask

    task automatic test_start_while_busy();
        run_load("start_busy", 14'h0040, 128'hF8F7F6F5F4F3F2F1, 8, 1'b0, 2);
        run_load("start_busy_w", 14'h0050, 128'h0C0B0A09, 4, 1'b0, 4 - 1);
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 14'h0020;
        @(posedge clk); #1;
        start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 8'hAA; bus.s_last = 1'b0;
        @(posedge clk); #1;
        bus.s_data = 8'hBB;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        run_load("after_reset", 14'h0005, 128'h0D0C0B0A, 4, 1'b0, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_word();
        test_partial_tail();
        test_wrap();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_load();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onchip_mem_stream_loader.md
# onchip_mem_stream_loader

Byte-stream to word-write loader placed directly upstream of the 10240 x 32 on-chip memory. It accepts an 8-bit valid/ready stream, for example from a UART or JTAG receiver. It packs bytes little-endian into 32-bit words and writes them through the memory's single-port write interface at consecutive word addresses. It is used to load program or data images into on-chip RAM without involving the Nios II.

## Interface
Parameters:
- ADDR_W, 14, memory word-address width.
- DEPTH, 10240, number of 32-bit words in the target memory; the address wraps at DEPTH-1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a load at start_addr. Ignored while busy=1.
- start_addr  in  ADDR_W  first word address; sampled when start is accepted.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_last  in  1  qualifies the final byte of the image.
- s_ready  out  1  the loader accepts a byte this cycle.
- mem_address  out  ADDR_W  word address to the memory.
- mem_byteenable  out  4  byte lanes written.
- mem_chipselect  out  1  memory select; high only in a write cycle.
- mem_write  out  1  write strobe; equal to mem_chipselect.
- mem_writedata  out  32  packed word.
- mem_clken  out  1  tied high.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final write.
- wrapped  out  1  sticky; set if the address wrapped during the current load.
- word_count  out  ADDR_W+1  number of words written in the current load.

## Operation
- The state machine has four states: IDLE, FILL, WRITE and DONE.
- IDLE:
  - s_ready=0.
  - When start=1, latch start_addr into the address register and clear lane, word_count and wrapped.
  - Go to FILL.
- FILL:
  - s_ready=1.
  - Each handshake (s_valid & s_ready) stores s_data into byte lane `lane`, that is, writedata[8*lane+7 : 8*lane], and sets the matching bit of the byteenable accumulator.
  - Lane 0 is the first byte of the word.
  - After the byte in lane 3 is accepted, or after any byte with s_last=1 is accepted, go to WRITE. Otherwise lane increments.
- WRITE:
  - s_ready=0.
  - mem_chipselect and mem_write are high for exactly one cycle, with the latched address, data and byteenable.
  - A partial final word has byteenable equal to the lanes filled so far, e.g. 4'b0011 for 2 bytes.
  - On exit:
    - word_count increments.
    - The address increments; at DEPTH-1 it wraps to 0 and sets wrapped.
    - lane is cleared and the byteenable accumulator is cleared.
    - Unused writedata lanes are zero.
  - If the word contained the last byte, go to DONE; else go to FILL.
- DONE:
  - done=1 for one cycle.
  - Go to IDLE.
  - word_count and wrapped hold their values until the next start.
- start while busy is ignored and has no effect.
- If s_last arrives on lane 3, only one write occurs and no empty trailing word is written.
- s_valid outside FILL is ignored; no byte is consumed.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - state IDLE;
  - s_ready=0, busy=0, done=0, wrapped=0;
  - mem_chipselect=0, mem_write=0, mem_byteenable=0;
  - mem_address=0, mem_writedata=0, word_count=0.
  - mem_clken=1 at all times.
- A reset mid-load aborts the load. No further write is issued and a partial word is discarded.
- All outputs are registered except mem_clken.
- start accepted at edge N gives busy=1 and s_ready=1 from cycle N+1.
- With continuous s_valid, a full word costs 5 cycles: 4 byte handshakes and 1 write cycle. The write cycle is the cycle immediately after the 4th handshake.
- done is high in the cycle after the final write cycle. busy falls together with done.
- The memory has no waitrequest, so every write completes in its single write cycle.

## Test plan
- Full-word load:
  - Stimulus: start_addr=0x0010, then bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88, with s_last on 0x88.
  - Required: writes 0x44332211 at 0x0010 and 0x88776655 at 0x0011, both with byteenable 4'hF.
  - Required: word_count=2, then a done pulse.
- Partial tail:
  - Stimulus: bytes 0xAA,0xBB,0xCC,0xDD,0xEE, with s_last on 0xEE, at start_addr 0.
  - Required: second write is data 0x000000EE with byteenable 4'b0001 at address 1.
- Wrap:
  - Stimulus: start_addr=10239, 8 bytes.
  - Required: writes at 10239 then 0; wrapped=1.
- Backpressure and gaps:
  - Stimulus: s_valid toggling randomly.
  - Required: s_ready=0 in every write cycle; byte order preserved; no byte lost or duplicated.
- Start while busy:
  - Stimulus: a second start with start_addr=0x0100 mid-load.
  - Required: ignored; addresses continue from the original start.
- Reset mid-load:
  - Stimulus: reset_n low after 2 bytes.
  - Required: all outputs return to reset values immediately; no write occurs.
  - Required: a new start then loads correctly from lane 0.
